dffram_arb2: RTL and testbench
==============================

# dffram_arb2

Two-port arbiter that shares a single-port DFFRAM macro (EN0/WE0/A0/Di0/Do0, one-cycle synchronous read, byte write enables) between two requesters, e.g. instruction fetch and load/store. It grants at most one access per cycle, drives the macro directly, and routes the read data returned one cycle later to the port that issued the access. Optional locked bursts give a port a guaranteed run of back-to-back accesses for read-modify-write sequences.

## Interface
- A_WIDTH, 9, word address width; must match the macro.
- MAX_BURST, 4, maximum consecutive locked grants to one port (2..16).

- CLK  in  1  clock; all state updates on its rising edge.
- RST  in  1  synchronous, active-high reset.
- pN_req  in  1  port N (N=0,1) requests an access this cycle.
- pN_we  in  4  port N byte write enables; 0 = read.
- pN_addr  in  A_WIDTH  port N word address.
- pN_wdata  in  32  port N write data.
- pN_lock  in  1  port N requests to keep the grant next cycle.
- pN_gnt  out  1  access accepted this cycle (combinational).
- pN_rvalid  out  1  response for port N's access of the previous cycle.
- pN_rdata  out  32  word at the accessed address before any write; 0 when pN_rvalid=0.
- ram_EN0  out  1  macro enable.
- ram_WE0  out  4  macro byte write enables.
- ram_A0  out  A_WIDTH  macro address.
- ram_Di0  out  32  macro write data.
- ram_Do0  in  32  macro read data; valid the cycle after ram_EN0.

## Operation
- Grant is combinational. The winner's we/addr/wdata are muxed onto ram_WE0/A0/Di0, and ram_EN0 = p0_gnt | p1_gnt. With no grant, ram_EN0=0 and ram_WE0=0; ram_A0 and ram_Di0 are don't-care.
- Only one port requesting: that port is granted.
- Both ports requesting, no active lock: the arbitration policy decides (see Configuration).
- Every grant, read or write, produces exactly one rvalid pulse the next cycle on the same port.
  - rdata = ram_Do0, passed through combinationally and gated by rvalid.
  - For a write, rdata returns the pre-write word.
- There is no response backpressure.
- The owner register (one bit) and rvalid flags are registered from the grant.
- Lock FSM states: IDLE, LOCK0, LOCK1.
  - IDLE -> LOCKn when port n is granted with pn_lock=1. burst_cnt is set to 1.
  - In LOCKn, while pn_req=1 and burst_cnt < MAX_BURST, port n wins unconditionally and burst_cnt increments per grant.
  - LOCKn -> IDLE when pn_req=0, or a grant is issued with pn_lock=0, or burst_cnt reaches MAX_BURST.
  - When the burst limit is hit with the other port requesting, the other port is granted in the following cycle regardless of policy.
- In LOCKn, if port n drops its request, the other port may be granted in that same cycle. The FSM returns to IDLE on that edge.
- pN_lock is ignored when pN_gnt=0.

## Timing
- Access latency: request accepted in cycle T (gnt=1), rvalid/rdata in cycle T+1.
- Throughput: one access per cycle. Grants may occur on consecutive cycles to the same or alternating ports; the rvalid of T+1 and the grant of T+1 coexist.
- A write at T followed by a read of the same address at T+1 returns the new data at T+2.
- Reset values, with RST high at an edge and for the following cycle:
  - All gnt=0, ram_EN0=0, ram_WE0=0, all rvalid=0, all rdata=0.
  - FSM=IDLE, burst_cnt=0, round-robin pointer = "port 0 next".
- Reset mid-operation: a response pending from the cycle before reset is dropped (no rvalid). An active lock is cancelled.
- The macro contents are not affected by RST.

## Configuration
- DFFRAM_ARB_RR_EN defined: round-robin policy. On contention in IDLE, the port not granted most recently wins. The pointer updates on every grant, including locked and uncontended grants.
- DFFRAM_ARB_RR_EN undefined: fixed priority, port 0 wins all contention in IDLE. Lock and burst-limit behaviour are unchanged, so port 1 still gets a slot after a capped port-0 burst.

## Test plan
- Solo write/read: p0 writes 0xDEADBEEF to addr 0x005 with we=4'hF, then reads 0x005 -> p0_rvalid on both following cycles; the second returns rdata=0xDEADBEEF; p1_rvalid stays 0.
- Byte lanes: write 0x11223344, then write 0xAABBCCDD with we=4'b0101, then read -> 0x11BB33DD. The write response returns 0x11223344.
- Contention: both ports request reads of different addresses for 4 cycles after reset.
  - With RR_EN: grants are p0,p1,p0,p1.
  - Without RR_EN: grants are p0 ×4.
  - Each rvalid lands on the correct port one cycle later.
- Locked burst, MAX_BURST=4: p1 locks and requests for 6 cycles while p0 requests continuously -> p1 granted 4 cycles, p0 granted the 5th, FSM back to IDLE.
- Reset mid-access: assert RST in the cycle after a p0 grant -> no p0_rvalid, ram_EN0=0, all outputs 0. The first post-reset contention grants p0.
- Lock release: p0 locks, then drops req while p1 requests -> p1 granted in that same cycle.

Source files
------------

// File: rtl/dffram_arb2.sv
// Two-port arbiter that shares one single-port DFFRAM macro, with optional locked bursts.
// Define DFFRAM_ARB_RR_EN for round-robin contention; otherwise port 0 has fixed priority.
module dffram_arb2 #(
    parameter int A_WIDTH   = 9,
    parameter int MAX_BURST = 4
) (
    input  logic               CLK,
    input  logic               RST,

    input  logic               p0_req,
    input  logic [3:0]         p0_we,
    input  logic [A_WIDTH-1:0] p0_addr,
    input  logic [31:0]        p0_wdata,
    input  logic               p0_lock,
    output logic               p0_gnt,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,

    input  logic               p1_req,
    input  logic [3:0]         p1_we,
    input  logic [A_WIDTH-1:0] p1_addr,
    input  logic [31:0]        p1_wdata,
    input  logic               p1_lock,
    output logic               p1_gnt,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,

    output logic               ram_EN0,
    output logic [3:0]         ram_WE0,
    output logic [A_WIDTH-1:0] ram_A0,
    output logic [31:0]        ram_Di0,
    input  logic [31:0]        ram_Do0
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } lock_state_t;

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    lock_state_t      state;
    logic [CNT_W-1:0] burst_cnt;
    logic             yield_pend;   // burst cap just hit: the other port is owed the next slot
    logic             yield_port;
    logic             resp_valid;
    logic             resp_owner;
`ifdef DFFRAM_ARB_RR_EN
    logic             rr_next;      // port favoured on the next IDLE contention
`endif

    logic gnt0_raw, gnt1_raw;
    logic any_gnt, winner;
    logic lk_port, lk_req, lk_lock, other_req, yield_req;

    assign lk_port   = (state == LOCK1);
    assign lk_req    = lk_port ? p1_req  : p0_req;
    assign lk_lock   = lk_port ? p1_lock : p0_lock;
    assign other_req = lk_port ? p0_req  : p1_req;
    assign yield_req = yield_port ? p1_req : p0_req;

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        gnt0_raw = 1'b0;
        gnt1_raw = 1'b0;
        if (state == LOCK0 && p0_req) begin
            gnt0_raw = 1'b1;
        end else if (state == LOCK1 && p1_req) begin
            gnt1_raw = 1'b1;
        end else if (yield_pend && yield_req) begin
            gnt0_raw = ~yield_port;
            gnt1_raw = yield_port;
        end else if (p0_req && p1_req) begin
`ifdef DFFRAM_ARB_RR_EN
            gnt0_raw = ~rr_next;
            gnt1_raw = rr_next;
`else
            gnt0_raw = 1'b1;
`endif
        end else begin
            gnt0_raw = p0_req;
            gnt1_raw = p1_req;
        end
    end

    // Reset masks grants and responses in the same cycle, so nothing leaks out while RST is high.
    assign p0_gnt  = gnt0_raw & ~RST;
    assign p1_gnt  = gnt1_raw & ~RST;
    assign any_gnt = p0_gnt | p1_gnt;
    assign winner  = p1_gnt;

    assign ram_EN0 = any_gnt;
    assign ram_WE0 = p1_gnt ? p1_we    : (p0_gnt ? p0_we    : 4'h0);
    assign ram_A0  = p1_gnt ? p1_addr  : (p0_gnt ? p0_addr  : '0);
    assign ram_Di0 = p1_gnt ? p1_wdata : (p0_gnt ? p0_wdata : 32'h0);

    assign p0_rvalid = resp_valid & ~resp_owner & ~RST;
    assign p1_rvalid = resp_valid &  resp_owner & ~RST;
    assign p0_rdata  = p0_rvalid ? ram_Do0 : 32'h0;
    assign p1_rdata  = p1_rvalid ? ram_Do0 : 32'h0;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            yield_pend <= 1'b0;
            yield_port <= 1'b0;
            resp_valid <= 1'b0;
            resp_owner <= 1'b0;
`ifdef DFFRAM_ARB_RR_EN
            rr_next    <= 1'b0;
`endif
        end else begin
            resp_valid <= any_gnt;
            if (any_gnt) begin
                resp_owner <= winner;
`ifdef DFFRAM_ARB_RR_EN
                rr_next    <= ~winner;
`endif
            end
            yield_pend <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_gnt && (winner ? p1_lock : p0_lock)) begin
                        state     <= winner ? LOCK1 : LOCK0;
                        burst_cnt <= CNT_W'(1);
                    end
                end
                LOCK0, LOCK1: begin
                    if (!lk_req) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else if (burst_cnt == LAST_CNT) begin
                        state      <= IDLE;
                        burst_cnt  <= '0;
                        yield_pend <= other_req;
                        yield_port <= ~lk_port;
                    end else if (!lk_lock) begin
                        state     <= IDLE;
                        burst_cnt <= '0;
                    end else begin
                        burst_cnt <= burst_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    burst_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dffram_arb2.sv
// Self-checking bench for dffram_arb2: directed scenarios, then random traffic against a reference model.
// Honours DFFRAM_ARB_RR_EN the same way as the design.
module tb_dffram_arb2;

    localparam int AW   = 9;
    localparam int MAXB = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          p0_req, p1_req, p0_lock, p1_lock;
    logic [3:0]    p0_we, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [31:0]   p0_wdata, p1_wdata;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]   p0_rdata, p1_rdata;
    logic          ram_EN0;
    logic [3:0]    ram_WE0;
    logic [AW-1:0] ram_A0;
    logic [31:0]   ram_Di0, ram_Do0;

    always #5 CLK = ~CLK;

    dffram_arb2 #(.A_WIDTH(AW), .MAX_BURST(MAXB)) dut (
        .CLK(CLK), .RST(RST),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_lock(p0_lock),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_lock(p1_lock),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .ram_EN0(ram_EN0), .ram_WE0(ram_WE0), .ram_A0(ram_A0), .ram_Di0(ram_Di0), .ram_Do0(ram_Do0)
    );

    // DFFRAM macro: synchronous read of the pre-write word, byte-masked write.
    logic [31:0] macro_mem [0:(1<<AW)-1];
    always @(posedge CLK) begin
        if (ram_EN0) begin
            ram_Do0 <= macro_mem[ram_A0];
            for (int b = 0; b < 4; b++)
                if (ram_WE0[b]) macro_mem[ram_A0][8*b +: 8] <= ram_Di0[8*b +: 8];
        end
    end

    // Reference model state, in terms of "who holds the lock", "how long", "who is owed a slot".
    int          m_locked = -1, m_run = 0, m_owed = -1, m_last = 1;
    logic [31:0] ref_mem   [0:(1<<AW)-1];
    bit          ref_known [0:(1<<AW)-1];
    bit          pend_v0 = 0, pend_v1 = 0, pend_known = 0;
    logic [31:0] pend_data = '0;

    int tests = 0, fails = 0;
    logic        obs_g0, obs_g1, obs_rv0, obs_rv1, obs_en;
    logic [31:0] obs_rd0, obs_rd1, obs_di;
    logic [AW-1:0] obs_a;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_winner();
        bit r [2];
        r[0] = p0_req;
        r[1] = p1_req;
        if (m_locked >= 0 && r[m_locked]) return m_locked;
        if (m_owed >= 0 && r[m_owed]) return m_owed;
        if (r[0] && r[1]) begin
`ifdef DFFRAM_ARB_RR_EN
            return 1 - m_last;
`else
            return 0;
`endif
        end
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic idle_inputs();
        p0_req = 0; p0_we = 4'h0; p0_addr = '0; p0_wdata = '0; p0_lock = 0;
        p1_req = 0; p1_we = 4'h0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
    endtask

    // One clock: compare every output against the model, then advance the model across the edge.
    task automatic run_cycle(input string tag);
        int          w, nowed;
        bit          r [2];
        bit          lk [2];
        logic [3:0]  we_w;
        logic [AW-1:0] a_w;
        logic [31:0] d_w;
        @(negedge CLK);
        w = RST ? -1 : model_winner();
        obs_g0 = p0_gnt;  obs_g1 = p1_gnt;  obs_rv0 = p0_rvalid; obs_rv1 = p1_rvalid;
        obs_rd0 = p0_rdata; obs_rd1 = p1_rdata; obs_en = ram_EN0; obs_a = ram_A0; obs_di = ram_Di0;
        we_w = (w == 1) ? p1_we : p0_we;
        a_w  = (w == 1) ? p1_addr : p0_addr;
        d_w  = (w == 1) ? p1_wdata : p0_wdata;
        check({tag, "_gnt0"}, p0_gnt, 32'(w == 0));
        check({tag, "_gnt1"}, p1_gnt, 32'(w == 1));
        check({tag, "_en"}, ram_EN0, 32'(w >= 0));
        check({tag, "_we"}, ram_WE0, (w >= 0) ? 32'(we_w) : 32'h0);
        if (w >= 0) begin
            check({tag, "_addr"}, ram_A0, 32'(a_w));
            if (we_w != 4'h0) check({tag, "_di"}, ram_Di0, d_w);
        end
        check({tag, "_rv0"}, p0_rvalid, 32'(!RST && pend_v0));
        check({tag, "_rv1"}, p1_rvalid, 32'(!RST && pend_v1));
        if (RST || !pend_v0) check({tag, "_rd0"}, p0_rdata, 32'h0);
        else if (pend_known) check({tag, "_rd0"}, p0_rdata, pend_data);
        if (RST || !pend_v1) check({tag, "_rd1"}, p1_rdata, 32'h0);
        else if (pend_known) check({tag, "_rd1"}, p1_rdata, pend_data);

        if (RST) begin
            m_locked = -1; m_run = 0; m_owed = -1; m_last = 1;
            pend_v0 = 0; pend_v1 = 0;
        end else begin
            pend_v0 = (w == 0);
            pend_v1 = (w == 1);
            if (w >= 0) begin
                pend_known = ref_known[a_w];
                pend_data  = ref_mem[a_w];
                for (int b = 0; b < 4; b++)
                    if (we_w[b]) ref_mem[a_w][8*b +: 8] = d_w[8*b +: 8];
                if (we_w == 4'hF) ref_known[a_w] = 1;
            end
            r[0] = p0_req;  r[1] = p1_req;
            lk[0] = p0_lock; lk[1] = p1_lock;
            nowed = -1;
            if (m_locked >= 0) begin
                if (r[m_locked]) begin
                    m_run++;
                    if (m_run == MAXB) begin
                        if (r[1 - m_locked]) nowed = 1 - m_locked;
                        m_locked = -1;
                    end else if (!lk[m_locked]) begin
                        m_locked = -1;
                    end
                end else begin
                    m_locked = -1;
                end
            end else if (w >= 0 && lk[w]) begin
                m_locked = w;
                m_run = 1;
            end
            m_owed = nowed;
            if (w >= 0) m_last = w;
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
            ref_known[i] = 0;
        end
        idle_inputs();
        RST = 1;
        @(posedge CLK);
        #1;
        run_cycle("reset_a");
        run_cycle("reset_b");
        RST = 0;

        // Fill the low addresses so later reads have known contents.
        for (int a = 0; a < 32; a++) begin
            p0_req = 1; p0_we = 4'hF; p0_addr = AW'(a); p0_wdata = $urandom;
            run_cycle("fill");
        end
        idle_inputs();
        run_cycle("fill_end");

        // Solo write then read of the same word.
        p0_req = 1; p0_we = 4'hF; p0_addr = AW'(5); p0_wdata = 32'hDEADBEEF;
        run_cycle("solo_wr");
        p0_we = 4'h0;
        run_cycle("solo_rd");
        check("solo_wr_rvalid", obs_rv0, 32'h1);
        idle_inputs();
        run_cycle("solo_idle");
        check("solo_rd_rvalid", obs_rv0, 32'h1);
        check("solo_rd_data", obs_rd0, 32'hDEADBEEF);
        check("solo_p1_quiet", obs_rv1, 32'h0);

        // Byte-lane write.
        p0_req = 1; p0_we = 4'hF; p0_addr = AW'(16); p0_wdata = 32'h11223344;
        run_cycle("lane_wr_full");
        p0_we = 4'b0101; p0_wdata = 32'hAABBCCDD;
        run_cycle("lane_wr_part");
        p0_we = 4'h0;
        run_cycle("lane_rd");
        check("lane_wr_resp", obs_rd0, 32'h11223344);
        idle_inputs();
        run_cycle("lane_idle");
        check("lane_rd_data", obs_rd0, 32'h11BB33DD);

        // Contention straight after reset.
        RST = 1;
        run_cycle("cont_rst");
        RST = 0;
        p0_req = 1; p0_addr = AW'(1); p1_req = 1; p1_addr = AW'(2);
        for (int i = 0; i < 4; i++) begin
            run_cycle("cont");
`ifdef DFFRAM_ARB_RR_EN
            check("cont_seq_p1", obs_g1, 32'(i % 2));
`else
            check("cont_seq_p1", obs_g1, 32'h0);
`endif
            if (i > 0) check("cont_rv_any", 32'(obs_rv0 | obs_rv1), 32'h1);
        end
        idle_inputs();
        run_cycle("cont_idle");

        // Locked burst capped at MAXB, other port owed the next slot.
        p1_req = 1; p1_lock = 1; p1_addr = AW'(3);
        run_cycle("burst_1");
        check("burst_1_p1", obs_g1, 32'h1);
        p0_req = 1; p0_addr = AW'(4);
        for (int i = 2; i <= 6; i++) begin
            run_cycle("burst");
            if (i <= 4) check("burst_p1_holds", obs_g1, 32'h1);
            if (i == 5) check("burst_p0_after_cap", obs_g0, 32'h1);
`ifdef DFFRAM_ARB_RR_EN
            if (i == 6) check("burst_6_rr_p1", obs_g1, 32'h1);
`else
            if (i == 6) check("burst_6_fixed_p0", obs_g0, 32'h1);
`endif
        end
        idle_inputs();
        run_cycle("burst_idle");

        // Reset in the cycle after a grant drops the pending response.
        p0_req = 1; p0_addr = AW'(5);
        run_cycle("rmid_gnt");
        check("rmid_gnt_p0", obs_g0, 32'h1);
        RST = 1; p1_req = 1; p1_addr = AW'(6);
        run_cycle("rmid_rst");
        check("rmid_no_rv0", obs_rv0, 32'h0);
        check("rmid_en", obs_en, 32'h0);
        check("rmid_a0", obs_a, 32'h0);
        check("rmid_di0", obs_di, 32'h0);
        check("rmid_rd0", obs_rd0, 32'h0);
        RST = 0;
        run_cycle("rmid_first");
        check("rmid_first_p0", obs_g0, 32'h1);
        idle_inputs();
        run_cycle("rmid_idle");

        // Lock release hands the slot to the other port in the same cycle.
        p0_req = 1; p0_lock = 1; p0_addr = AW'(7);
        run_cycle("rel_lock");
        p1_req = 1; p1_addr = AW'(8);
        run_cycle("rel_hold");
        check("rel_hold_p0", obs_g0, 32'h1);
        p0_req = 0; p0_lock = 0;
        run_cycle("rel_drop");
        check("rel_drop_p1", obs_g1, 32'h1);
        idle_inputs();
        run_cycle("rel_idle");

        // Random traffic against the model.
        for (int i = 0; i < 800; i++) begin
            RST      = ($urandom_range(0, 99) == 0);
            p0_req   = ($urandom_range(0, 9) < 7);
            p1_req   = ($urandom_range(0, 9) < 7);
            p0_lock  = ($urandom_range(0, 2) == 0);
            p1_lock  = ($urandom_range(0, 2) == 0);
            p0_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            p1_we    = $urandom_range(0, 1) ? 4'($urandom) : 4'h0;
            p0_addr  = AW'($urandom_range(0, 31));
            p1_addr  = AW'($urandom_range(0, 31));
            p0_wdata = $urandom;
            p1_wdata = $urandom;
            run_cycle("rand");
        end
        RST = 0;
        idle_inputs();
        run_cycle("rand_end");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
